// File: rtl/wb_defs.sv
// ---------------------------------------------------------------------------
// wb_defs
//   Shared definitions for the Wishbone burst-read master.
//   - Wishbone B3 cycle-type (CTI) and burst-type (BTE) encodings
//   - FSM state encoding for the burst reader
//   - small unsigned min helper used for burst sizing
// ---------------------------------------------------------------------------
package wb_defs;

  // Cycle type identifiers driven on wb_cti_o
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Burst type: only linear incrementing bursts are issued
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  // Burst reader sequencing states
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_SPACE = 2'd1,
    ST_BURST      = 2'd2
  } state_t;

  // Unsigned minimum of two 32-bit quantities
  function automatic logic [31:0] min_u32(input logic [31:0] a,
                                          input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/wb_burst_reader_fifo.sv
// ---------------------------------------------------------------------------
// wb_burst_reader_fifo
//   Synchronous first-word-fall-through FIFO holding read data between the
//   Wishbone side and the output stream. The head word is taken straight from
//   the storage registers, so a pushed word appears on dout one cycle after
//   the push edge. A simultaneous push and pop are both honoured, even when
//   full; a pop while empty is ignored.
//
// Parameters
//   AW     log2 of the depth
//   DW     data width
// Ports
//   clk    clock, rising edge
//   rst    synchronous active-high reset (empties the FIFO)
//   push   write din this cycle
//   din    write data
//   pop    consume the head word this cycle
//   dout   head word (valid while !empty)
//   count  number of stored words (0 .. 2^AW)
//   full   count == 2^AW
//   empty  count == 0
// ---------------------------------------------------------------------------
module wb_burst_reader_fifo #(
  parameter int AW = 4,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot a push into a full FIFO needs
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; only words below count are ever observable
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/wb_burst_reader.sv
// ---------------------------------------------------------------------------
// wb_burst_reader
//   Wishbone B3 burst-read master. A command (start byte address, word count)
//   is split into linear incrementing bursts that never cross a
//   BURST_LEN*4-byte aligned boundary. A burst only starts once the FIFO has
//   room for every beat of it, so the master never has to stall mid-burst and
//   the FIFO can never overflow. Bursts are separated by at least one idle
//   cycle on cyc so the upstream arbiter can rotate.
//
// Optional feature (macro WB_BURST_READER_ERR_EN)
//   When defined, wb_err_i during a burst ends the command: the errored beat
//   is not pushed, the cycle drops, and err pulses together with done.
//   When undefined, wb_err_i is ignored and the err port does not exist.
//
// Parameters
//   BURST_LEN   max beats per burst (power of 2, 1..16)
//   FIFO_AW     log2 FIFO depth; 2^FIFO_AW >= BURST_LEN
//   LEN_WIDTH   width of the word-count field
// Ports
//   wb_clk, wb_rst            clock / synchronous active-high reset
//   cmd_valid, cmd_ready      command handshake (ready only when idle)
//   cmd_adr, cmd_len          start byte address / number of 32-bit words
//   busy                      command in progress
//   done                      one-cycle completion pulse
//   dout, dout_valid, dout_ready  read data stream
//   wb_adr_o .. wb_dat_o      Wishbone master outputs
//   wb_dat_i, wb_ack_i, wb_err_i  Wishbone slave responses
//   err                       error pulse (only with WB_BURST_READER_ERR_EN)
// ---------------------------------------------------------------------------
module wb_burst_reader
  import wb_defs::*;
#(
  parameter int BURST_LEN = 8,
  parameter int FIFO_AW   = 4,
  parameter int LEN_WIDTH = 16
) (
  input  logic                 wb_clk,
  input  logic                 wb_rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [31:0]          cmd_adr,
  input  logic [LEN_WIDTH-1:0] cmd_len,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic [31:0]          wb_adr_o,
  output logic                 wb_stb_o,
  output logic                 wb_cyc_o,
  output logic [2:0]           wb_cti_o,
  output logic [1:0]           wb_bte_o,
  output logic                 wb_we_o,
  output logic [3:0]           wb_sel_o,
  output logic [31:0]          wb_dat_o,
  input  logic [31:0]          wb_dat_i,
  input  logic                 wb_ack_i,
`ifdef WB_BURST_READER_ERR_EN
  input  logic                 wb_err_i,
  output logic                 err
`else
  input  logic                 wb_err_i
`endif
);

  localparam int CNT_W      = $clog2(BURST_LEN + 1);
  localparam int FIFO_DEPTH = 1 << FIFO_AW;

  state_t               state_q, state_d;
  logic [31:0]          adr_q, adr_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 done_q, done_d;
`ifdef WB_BURST_READER_ERR_EN
  logic                 err_q, err_d;
  logic                 beat_err;
`endif

  logic                 in_burst;
  logic                 beat_ack;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic [FIFO_AW:0]     fifo_count;
  logic                 fifo_full;
  logic                 fifo_empty;

  logic [31:0]          free_words;
  logic [31:0]          word_idx;
  logic [31:0]          boundary_words;
  logic [31:0]          rem_words;
  logic [31:0]          blen;

  assign in_burst = (state_q == ST_BURST);

`ifdef WB_BURST_READER_ERR_EN
  // An error terminates the beat instead of completing it
  assign beat_err = in_burst && wb_err_i;
  assign beat_ack = in_burst && wb_ack_i && !wb_err_i;
`else
  assign beat_ack = in_burst && wb_ack_i;
`endif

  // Burst sizing: stop at the next BURST_LEN-word aligned boundary or at the
  // end of the command, whichever comes first. Done in 32-bit arithmetic so
  // BURST_LEN == 1 needs no special-cased bit slice.
  assign word_idx       = {2'b00, adr_q[31:2]};
  assign boundary_words = 32'(BURST_LEN) - (word_idx & 32'(BURST_LEN - 1));
  assign rem_words      = 32'(rem_q);
  assign blen           = min_u32(rem_words, boundary_words);
  assign free_words     = 32'(FIFO_DEPTH) - 32'(fifo_count);

  // Next-state and datapath updates for the command sequencer
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
`ifdef WB_BURST_READER_ERR_EN
    err_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          adr_d = {cmd_adr[31:2], 2'b00};
          rem_d = cmd_len;
          if (cmd_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_WAIT_SPACE;
          end
        end
      end
      ST_WAIT_SPACE: begin
        // Space for the whole burst is reserved before cyc is raised
        if (free_words >= blen) begin
          state_d = ST_BURST;
          cnt_d   = blen[CNT_W-1:0];
        end
      end
      ST_BURST: begin
`ifdef WB_BURST_READER_ERR_EN
        if (beat_err) begin
          state_d = ST_IDLE;
          rem_d   = '0;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else
`endif
        if (beat_ack) begin
          adr_d = adr_q + 32'd4;
          rem_d = rem_q - LEN_WIDTH'(1);
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            if (rem_q == LEN_WIDTH'(1)) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_WAIT_SPACE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q <= ST_IDLE;
      adr_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
`ifdef WB_BURST_READER_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
`ifdef WB_BURST_READER_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  assign fifo_push = beat_ack;
  assign fifo_pop  = dout_ready;

  wb_burst_reader_fifo #(
    .AW (FIFO_AW),
    .DW (32)
  ) u_fifo (
    .clk   (wb_clk),
    .rst   (wb_rst),
    .push  (fifo_push),
    .din   (wb_dat_i),
    .pop   (fifo_pop),
    .dout  (dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Command side
  assign cmd_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
`ifdef WB_BURST_READER_ERR_EN
  assign err        = err_q;
`endif
  assign dout_valid = !fifo_empty;

  // Wishbone side: cyc/stb are a decode of the registered state, so they
  // drop the cycle after the final ack and stay low through WAIT_SPACE
  assign wb_cyc_o = in_burst;
  assign wb_stb_o = in_burst;
  assign wb_adr_o = adr_q;
  assign wb_cti_o = !in_burst              ? CTI_CLASSIC :
                    (cnt_q == CNT_W'(1))   ? CTI_EOB     : CTI_INC;
  assign wb_bte_o = BTE_LINEAR;
  assign wb_we_o  = 1'b0;
  assign wb_sel_o = 4'hF;
  assign wb_dat_o = 32'h0;

  // Byte-offset bits of the address, the full flag (space is reserved up
  // front) and, in the default build, the error input carry no information
  logic unused_inputs;
`ifdef WB_BURST_READER_ERR_EN
  assign unused_inputs = ^{cmd_adr[1:0], fifo_full};
`else
  assign unused_inputs = ^{cmd_adr[1:0], fifo_full, wb_err_i};
`endif

endmodule

// File: doc/wb_burst_reader.md
Name: wb_burst_reader

Overview:
- Wishbone B3 burst-read master (initiator), used as the requesting side of one arbiter port on the SDRAM controller (e.g. framebuffer scan-out, blitter source fetch).
- Accepts a command (start byte address, word count) and splits it into linear incrementing bursts aligned to the SDRAM burst size.
- Read data goes into an internal FIFO and leaves on a valid/ready stream.

Parameters:
- BURST_LEN, 8, max beats per Wishbone burst (power of 2, 1..16); matches controller BURST_LENGTH.
- FIFO_AW, 4, FIFO depth = 2^FIFO_AW words; must satisfy 2^FIFO_AW >= BURST_LEN.
- LEN_WIDTH, 16, width of the word-count field.

Ports:
- wb_clk  in  1  clock; all logic on rising edge.
- wb_rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_adr  in  32  start byte address; bits [1:0] ignored (treated as 0).
- cmd_len  in  LEN_WIDTH  number of 32-bit words.
- busy  out  1  command in progress (not IDLE).
- done  out  1  one-cycle pulse when the last word of a command is acked, or when a zero-length command completes.
- dout  out  32  stream data.
- dout_valid  out  1  FIFO not empty.
- dout_ready  in  1  consumer pop.
- wb_adr_o  out  32  word-aligned address.
- wb_stb_o / wb_cyc_o  out  1  strobe / cycle; always asserted together.
- wb_cti_o  out  3  010 on incrementing beats, 111 on last beat.
- wb_bte_o  out  2  constant 00 (linear).
- wb_we_o  out  1  constant 0.
- wb_sel_o  out  4  constant 1111.
- wb_dat_o  out  32  constant 0.
- wb_dat_i  in  32  read data.
- wb_ack_i  in  1  beat acknowledge.
- wb_err_i  in  1  bus error; only used with the optional feature.

Behaviour:
- Reset values:
  - cmd_ready=1; busy=0; done=0; dout_valid=0.
  - wb_cyc_o=0, wb_stb_o=0, wb_cti_o=000, wb_adr_o=0.
  - FIFO emptied; FSM goes to IDLE.
- FSM states:
  - IDLE: on cmd_valid&cmd_ready, latch adr={cmd_adr[31:2],2'b00} and rem=cmd_len. If cmd_len==0, pulse done next cycle and stay in IDLE; otherwise go to WAIT_SPACE.
  - WAIT_SPACE: compute blen = min(rem, BURST_LEN - adr[2+log2(BURST_LEN)-1:2]), so a burst never crosses a BURST_LEN*4-byte aligned boundary. When FIFO free entries >= blen, go to BURST next cycle with cyc/stb=1, wb_adr_o=adr, beat counter=blen.
  - BURST: on each wb_ack_i:
    - push wb_dat_i into the FIFO;
    - adr+=4; rem-=1; counter-=1.
    - wb_cti_o=111 when counter==1 (a single-beat burst is 111 from its first cycle), otherwise 010.
    - On the ack of the final beat, deassert cyc/stb the next cycle. Go to WAIT_SPACE if rem>0; otherwise go to IDLE and pulse done in that same transition cycle.
- Master never deasserts stb mid-burst. FIFO space is reserved up front, so a push never overflows.
- No back-to-back bursts: cyc stays low at least one cycle between bursts, allowing arbiter rotation.
- Address wraps 0xFFFFFFFC→0x00000000 without error.
- FIFO:
  - push and pop in the same cycle are both honoured; count unchanged.
  - dout is registered: first-word latency 1 cycle after the push.
  - pop when empty is ignored.
- cmd_valid while busy is ignored: cmd_ready=0 and no latch.
- Reset mid-burst: cyc/stb low after the reset edge; partial data is discarded; no done pulse.
- rem arithmetic is LEN_WIDTH wide. Max command is 2^LEN_WIDTH-1 words.

Optional Feature:
- Macro WB_BURST_READER_ERR_EN.
- Defined:
  - wb_err_i during BURST is treated as terminating the beat: no push, and cyc/stb drop next cycle.
  - FSM returns to IDLE, rem is cleared, and an extra output err (1 bit, reset 0) pulses together with done.
- Undefined: wb_err_i is unused, err is absent, and an error beat is ignored (the master keeps waiting for ack).

Decomposition:
- Shared package (wb_defs): CTI constants (CTI_CLASSIC=000, CTI_INC=010, CTI_EOB=111), BTE_LINEAR=00, and FSM state encodings.
- One sub-module: wb_burst_reader_fifo, a synchronous FWFT FIFO with parameter AW and outputs count, full, empty. The parent derives free = 2^AW - count.

Test Plan:
- adr=0x100, len=16, slave acks every cycle, dout_ready=1 → two 8-beat bursts at 0x100 and 0x120; cti 010×7 then 111 in each; 16 words out in order; one done pulse.
- adr=0x118, len=5 → burst of 2 beats (0x118, 0x11C) then a burst of 3 beats at 0x120; cti of the last beat is 111 in each.
- len=1 → single beat with cti=111, one word out, done pulse.
- len=0 → no cyc, done pulse one cycle after the handshake.
- dout_ready=0, len=32, FIFO_AW=4 → exactly 16 words fetched, then cyc stays low. Raising dout_ready lets fetch resume; all 32 words arrive in order with no loss.
- wb_rst asserted during the 3rd beat → cyc/stb/dout_valid all 0 the next cycle, cmd_ready=1, no done pulse. With ERR_EN: wb_err_i on beat 2 → err and done pulse, FSM back in IDLE, one word in the FIFO.
